// File: rtl/arbitro_rr_2x1_pkg.sv
// Shared constants and state encoding for the 2:1 round-robin lane arbiter.
package arbitro_rr_2x1_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned MAX_BURST_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e serve_state(input logic src);
    serve_state = src ? SERVE1 : SERVE0;
  endfunction

endpackage

// File: rtl/arbitro_rr_2x1_if.sv
// Requester/downstream signal bundle of the arbiter; slave is the arbiter side.
interface arbitro_rr_2x1_if
  import arbitro_rr_2x1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] data_in0;
  logic              valid_in0;
  logic              ready_out0;
  logic [DATA_W-1:0] data_in1;
  logic              valid_in1;
  logic              ready_out1;
  logic              pause;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              sel_out;

  modport slave (
    input  data_in0, valid_in0, data_in1, valid_in1, pause,
    output ready_out0, ready_out1, data_out, valid_out, sel_out
  );

  modport master (
    output data_in0, valid_in0, data_in1, valid_in1, pause,
    input  ready_out0, ready_out1, data_out, valid_out, sel_out
  );

endinterface

// File: rtl/arbitro_rr_2x1_fifo_sync.sv
// Small synchronous FIFO with combinational head word; a full FIFO never
// accepts a push, even when it is popped in the same cycle.
module fifo_sync
  import arbitro_rr_2x1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == CNT_W'(0));
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next storage, pointers (wrap by power-of-two width) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= DATA_W'(0);
      end
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      cnt_q    <= CNT_W'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/arbitro_rr_2x1.sv
// Work-conserving round-robin arbiter draining two input FIFOs onto one
// registered lane, with bounded bursts and downstream pause.
module arbitro_rr_2x1
  import arbitro_rr_2x1_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  arbitro_rr_2x1_if.slave   bus
);

  localparam int unsigned          BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0]   BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0]   BURST_ONE = BURST_W'(1);

  arb_state_e        state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sel_q, sel_d;

  logic [DATA_W-1:0] dout0, dout1;
  logic              full0, full1, empty0, empty1;
  logic              do_pop, src;
  logic              own, own_empty, oth_empty;

  assign bus.ready_out0 = ~full0 & ~reset;
  assign bus.ready_out1 = ~full1 & ~reset;

  fifo_sync #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (bus.valid_in0 & bus.ready_out0),
    .pop   (do_pop & ~src),
    .din   (bus.data_in0),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0)
  );

  fifo_sync #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (bus.valid_in1 & bus.ready_out1),
    .pop   (do_pop & src),
    .din   (bus.data_in1),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1)
  );

  assign own       = (state_q == SERVE1);
  assign own_empty = own ? empty1 : empty0;
  assign oth_empty = own ? empty0 : empty1;

  // Arbitration decision and next output word; pause freezes all sequencing.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    sel_d   = sel_q;
    data_d  = DATA_W'(0);
    valid_d = 1'b0;
    do_pop  = 1'b0;
    src     = 1'b0;
    if (!bus.pause) begin
      case (state_q)
        IDLE: begin
          if (!empty0 && !empty1) begin
            do_pop = 1'b1;
            src    = ~last_q;
          end else if (!empty0) begin
            do_pop = 1'b1;
            src    = 1'b0;
          end else if (!empty1) begin
            do_pop = 1'b1;
            src    = 1'b1;
          end else begin
            do_pop = 1'b0;
          end
          if (do_pop) begin
            state_d = serve_state(src);
            burst_d = BURST_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        SERVE0, SERVE1: begin
          // Stay while under budget, or past it when the other side is idle.
          if (!own_empty && ((burst_q < BURST_MAX) || oth_empty)) begin
            do_pop  = 1'b1;
            src     = own;
            burst_d = (burst_q == BURST_MAX) ? BURST_MAX : burst_q + BURST_ONE;
          end else if (!oth_empty) begin
            do_pop  = 1'b1;
            src     = ~own;
            state_d = serve_state(~own);
            burst_d = BURST_ONE;
          end else begin
            state_d = IDLE;
            burst_d = BURST_W'(0);
          end
        end
        default: begin
          state_d = IDLE;
          burst_d = BURST_W'(0);
        end
      endcase
      if (do_pop) begin
        last_d  = src;
        sel_d   = src;
        valid_d = 1'b1;
        data_d  = src ? dout1 : dout0;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Arbiter state and registered output lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= BURST_W'(0);
      last_q  <= 1'b1;
      data_q  <= DATA_W'(0);
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.sel_out   = sel_q;

endmodule
